// File: rtl/pipo_arbiter.sv
// pipo_arbiter: four-requester round-robin arbiter feeding one shared
// 4-bit parallel-in/parallel-out register.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   rst      - asynchronous, active-high reset
//   req[3:0] - one request bit per requester
//   pi[15:0] - requester i data on pi[4i+3:4i]
//   out_rdy  - consumer accepts po when high while po_vld is high
//   gnt[3:0] - one-hot grant, high for exactly one cycle per capture
//   po[3:0]  - registered output word
//   po_vld   - po holds unconsumed data
//   busy     - high whenever the arbiter is not IDLE
//
// Build option: define PIPO_ARB_STREAM_EN to let HOLD with out_rdy=1 and
// a pending request capture again on the same edge (one word per cycle).
// Without it every transfer passes through an IDLE cycle.

module pipo_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] pi,
    input  logic        out_rdy,
    output logic [3:0]  gnt,
    output logic [3:0]  po,
    output logic        po_vld,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  po_q, po_d;
    logic        po_vld_q, po_vld_d;

    logic [1:0]  win;
    logic        found;
    logic [1:0]  idx;
    logic        cap;

    // Round-robin pick: first set req bit starting just above the last
    // winner, wrapping 3->0. The last winner itself is checked last.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = 4'b0000;
        po_d     = po_q;
        po_vld_d = po_vld_q;
        cap      = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    cap = 1'b1;
                end
            end
            HOLD: begin
                // With out_rdy low, req and pi are ignored entirely.
                if (out_rdy) begin
`ifdef PIPO_ARB_STREAM_EN
                    if (|req) begin
                        cap = 1'b1;
                    end else begin
                        po_vld_d = 1'b0;
                        state_d  = IDLE;
                    end
`else
                    po_vld_d = 1'b0;
                    state_d  = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap) begin
            state_d  = HOLD;
            gnt_d    = 4'b0001 << win;
            po_d     = pi[{win, 2'b00} +: 4];
            po_vld_d = 1'b1;
            ptr_d    = win;
        end
    end

    // ptr resets to 3 so requester 0 has top priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd3;
            gnt_q    <= 4'b0000;
            po_q     <= 4'b0000;
            po_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            po_q     <= po_d;
            po_vld_q <= po_vld_d;
        end
    end

    assign gnt    = gnt_q;
    assign po     = po_q;
    assign po_vld = po_vld_q;
    assign busy   = (state_q != IDLE);

endmodule
